board_datapath: RTL

BOARD_DATAPATH -- requirements
Module: board_datapath

---
 rtl/gomoku_pkg.sv | 50 +++++
 rtl/board_datapath_if.sv | 26 ++
 rtl/board_regs.sv | 36 +++
 rtl/board_datapath.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/gomoku_pkg.sv
// rtl/gomoku_pkg.sv - board size, cell/state encodings, direction table and coordinate helpers
package gomoku_pkg;

  localparam int BOARD_N = 15;
  localparam int CELLS   = BOARD_N * BOARD_N;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BLACK = 2'b01;
  localparam logic [1:0] WHITE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_POS      = 3'd1,
    ST_NEG      = 3'd2,
    ST_NEXT_DIR = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Scan order: horizontal, vertical, diagonal, anti-diagonal
  localparam logic signed [1:0] DIR_DX [4] = '{2'sd1, 2'sd0, 2'sd1, 2'sd1};
  localparam logic signed [1:0] DIR_DY [4] = '{2'sd0, 2'sd1, 2'sd1, -2'sd1};

  function automatic logic in_board(input logic [3:0] cx, input logic [3:0] cy);
    return (cx < 4'(BOARD_N)) && (cy < 4'(BOARD_N));
  endfunction

  function automatic logic [7:0] cell_idx(input logic [3:0] cx, input logic [3:0] cy);
    return ({4'd0, cy} * 8'd15) + {4'd0, cx};
  endfunction

  function automatic logic in_range5(input logic signed [4:0] c);
    return !c[4] && (c[3:0] != 4'd15);
  endfunction

  // Wrap-around of the 5-bit sum always lands outside 0..14, so range checks stay valid
  function automatic logic signed [4:0] coord_step(input logic [3:0] base,
                                                   input logic signed [1:0] d,
                                                   input logic [2:0] step,
                                                   input logic neg);
    logic signed [4:0] b;
    logic signed [4:0] off;
    b   = $signed({1'b0, base});
    off = $signed({2'b00, step});
    if (neg) off = -off;
    if (d == 2'sd0) return b;
    else if (d[1]) return b - off;
    else return b + off;
  endfunction

endpackage

// File: rtl/board_datapath_if.sv
// rtl/board_datapath_if.sv - placement request, display read and game status signals
interface board_datapath_if;
  logic       control_set;
  logic       change_turn;
  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic [1:0] rd_cell;
  logic       player;
  logic       busy;
  logic       reject;
  logic       win;
  logic       winner;
  logic       draw;

  modport master (
    output control_set, change_turn, x, y, rd_x, rd_y,
    input  rd_cell, player, busy, reject, win, winner, draw
  );

  modport slave (
    input  control_set, change_turn, x, y, rd_x, rd_y,
    output rd_cell, player, busy, reject, win, winner, draw
  );
endinterface

// File: rtl/board_regs.sv
// rtl/board_regs.sv - 15x15 board of 2-bit cells, one write port, checker and display read ports
module board_regs
  import gomoku_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       we,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic [1:0] wr_cell,
  input  logic [3:0] chk_x,
  input  logic [3:0] chk_y,
  output logic [1:0] chk_cell,
  input  logic [3:0] disp_x,
  input  logic [3:0] disp_y,
  output logic [1:0] disp_cell
);

  logic [1:0] cells_q [CELLS];
  logic [1:0] cells_d [CELLS];

  always_comb begin
    cells_d = cells_q;
    if (we && in_board(wr_x, wr_y)) cells_d[cell_idx(wr_x, wr_y)] = wr_cell;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cells_q <= '{default: EMPTY};
    else         cells_q <= cells_d;
  end

  // Out-of-board coordinates never index the array
  assign chk_cell  = in_board(chk_x, chk_y)   ? cells_q[cell_idx(chk_x, chk_y)]   : EMPTY;
  assign disp_cell = in_board(disp_x, disp_y) ? cells_q[cell_idx(disp_x, disp_y)] : EMPTY;

endmodule

// File: rtl/board_datapath.sv
// rtl/board_datapath.sv - gomoku move acceptance and five-in-a-row checker around the board registers
module board_datapath
  import gomoku_pkg::*;
(
  input  logic            clock,
  input  logic            resetn,
  board_datapath_if.slave bus
);

  state_t            state_q, state_d;
  logic [1:0]        dir_q, dir_d;
  logic [2:0]        step_q, step_d;
  logic [2:0]        count_q, count_d;
  logic [3:0]        last_x_q, last_x_d;
  logic [3:0]        last_y_q, last_y_d;
  logic [1:0]        last_colour_q, last_colour_d;
  logic [7:0]        move_cnt_q, move_cnt_d;
  logic              player_q, player_d;
  logic              reject_q, reject_d;
  logic              win_q, win_d;
  logic              winner_q, winner_d;
  logic              draw_q, draw_d;

  logic              busy;
  logic              we;
  logic [1:0]        wr_cell;
  logic signed [4:0] scan_x, scan_y;
  logic              scan_ok, hit, place_ok;
  logic [3:0]        chk_x, chk_y;
  logic [1:0]        chk_cell;

  assign busy    = (state_q == ST_POS) || (state_q == ST_NEG) || (state_q == ST_NEXT_DIR);
  assign scan_x  = coord_step(last_x_q, DIR_DX[dir_q], step_q, state_q == ST_NEG);
  assign scan_y  = coord_step(last_y_q, DIR_DY[dir_q], step_q, state_q == ST_NEG);
  assign scan_ok = in_range5(scan_x) && in_range5(scan_y);
  // The checker read port serves the scan while busy and the placement test otherwise
  assign chk_x    = busy ? scan_x[3:0] : bus.x;
  assign chk_y    = busy ? scan_y[3:0] : bus.y;
  assign hit      = scan_ok && (chk_cell == last_colour_q);
  assign place_ok = (bus.x <= 4'd14) && (bus.y <= 4'd14) && (chk_cell == EMPTY);
  assign wr_cell  = player_q ? WHITE : BLACK;

  board_regs u_board (
    .clock     (clock),
    .resetn    (resetn),
    .we        (we),
    .wr_x      (bus.x),
    .wr_y      (bus.y),
    .wr_cell   (wr_cell),
    .chk_x     (chk_x),
    .chk_y     (chk_y),
    .chk_cell  (chk_cell),
    .disp_x    (bus.rd_x),
    .disp_y    (bus.rd_y),
    .disp_cell (bus.rd_cell)
  );

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    step_d        = step_q;
    count_d       = count_q;
    last_x_d      = last_x_q;
    last_y_d      = last_y_q;
    last_colour_d = last_colour_q;
    move_cnt_d    = move_cnt_q;
    player_d      = player_q;
    reject_d      = 1'b0;
    win_d         = win_q;
    winner_d      = winner_q;
    draw_d        = draw_q;
    we            = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.control_set && !draw_q) begin
          if (place_ok) begin
            we            = 1'b1;
            last_x_d      = bus.x;
            last_y_d      = bus.y;
            last_colour_d = wr_cell;
            move_cnt_d    = move_cnt_q + 8'd1;
            if (bus.change_turn) player_d = ~player_q;
            dir_d         = 2'd0;
            count_d       = 3'd1;
            step_d        = 3'd1;
            state_d       = ST_POS;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_POS, ST_NEG: begin
        if (hit && (count_q == 3'd4)) begin
          state_d  = ST_DONE;
          win_d    = 1'b1;
          winner_d = (last_colour_q == WHITE);
        end else if (hit && (step_q != 3'd4)) begin
          count_d = count_q + 3'd1;
          step_d  = step_q + 3'd1;
        end else begin
          if (hit) count_d = count_q + 3'd1;
          step_d  = 3'd1;
          state_d = (state_q == ST_POS) ? ST_NEG : ST_NEXT_DIR;
        end
      end
      ST_NEXT_DIR: begin
        if (dir_q == 2'd3) begin
          state_d = ST_IDLE;
          if (move_cnt_q == 8'd225) draw_d = 1'b1;
        end else begin
          dir_d   = dir_q + 2'd1;
          count_d = 3'd1;
          step_d  = 3'd1;
          state_d = ST_POS;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      dir_q         <= 2'd0;
      step_q        <= 3'd1;
      count_q       <= 3'd1;
      last_x_q      <= 4'd0;
      last_y_q      <= 4'd0;
      last_colour_q <= EMPTY;
      move_cnt_q    <= 8'd0;
      player_q      <= 1'b0;
      reject_q      <= 1'b0;
      win_q         <= 1'b0;
      winner_q      <= 1'b0;
      draw_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      step_q        <= step_d;
      count_q       <= count_d;
      last_x_q      <= last_x_d;
      last_y_q      <= last_y_d;
      last_colour_q <= last_colour_d;
      move_cnt_q    <= move_cnt_d;
      player_q      <= player_d;
      reject_q      <= reject_d;
      win_q         <= win_d;
      winner_q      <= winner_d;
      draw_q        <= draw_d;
    end
  end

  assign bus.player = player_q;
  assign bus.busy   = busy;
  assign bus.reject = reject_q;
  assign bus.win    = win_q;
  assign bus.winner = winner_q;
  assign bus.draw   = draw_q;

endmodule
